// File: rtl/spi_cs_sequencer.sv
// Transaction front end for SPI_Master: feeds an N-byte user stream into the master,
// owns chip-select lead/trail/idle timing and returns indexed MISO bytes.
module spi_cs_sequencer #(
  parameter int MAX_BYTES_PER_CS = 4,
  parameter int CS_LEAD_CLKS     = 2,
  parameter int CS_TRAIL_CLKS    = 2,
  parameter int CS_IDLE_CLKS     = 4,
  parameter int CNT_W            = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic [CNT_W-1:0] i_TX_Count,
  input  logic [7:0]       i_TX_Byte,
  input  logic             i_TX_DV,
  output logic             o_TX_Ready,
  output logic [CNT_W-1:0] o_RX_Count,
  output logic             o_RX_DV,
  output logic [7:0]       o_RX_Byte,
  output logic [7:0]       o_M_MOSI_Byte,
  output logic             o_M_MOSI_DV,
  input  logic             i_M_MOSI_Ready,
  input  logic             i_M_MISO_DV,
  input  logic [7:0]       i_M_MISO_Byte,
  output logic             o_SPI_CS_n
);

  localparam int TMR_MAX_A = (CS_LEAD_CLKS > CS_TRAIL_CLKS) ? CS_LEAD_CLKS : CS_TRAIL_CLKS;
  localparam int TMR_MAX   = (TMR_MAX_A > CS_IDLE_CLKS) ? TMR_MAX_A : CS_IDLE_CLKS;
  localparam int TMR_W     = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0] LEAD_LAST  = TMR_W'(CS_LEAD_CLKS - 1);
  localparam logic [TMR_W-1:0] TRAIL_LAST = TMR_W'(CS_TRAIL_CLKS - 1);
  localparam logic [TMR_W-1:0] IDLE_LAST  = TMR_W'(CS_IDLE_CLKS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_BYTES_PER_CS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_SEND, S_WAIT, S_NEXT, S_TRAIL, S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic             csN_q, csN_d;
  logic             txReady_q, txReady_d;
  logic [7:0]       mosiByte_q, mosiByte_d;
  logic             mosiDv_q, mosiDv_d;
  logic             rxDv_q, rxDv_d;
  logic [7:0]       rxByte_q, rxByte_d;
  logic [CNT_W-1:0] rxCount_q, rxCount_d;
  logic [CNT_W-1:0] rxIdx_q, rxIdx_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic accept;
  assign accept = i_TX_DV & txReady_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= S_IDLE;
      csN_q      <= 1'b1;
      txReady_q  <= 1'b0;
      mosiByte_q <= '0;
      mosiDv_q   <= 1'b0;
      rxDv_q     <= 1'b0;
      rxByte_q   <= '0;
      rxCount_q  <= '0;
      rxIdx_q    <= '0;
      remain_q   <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      csN_q      <= csN_d;
      txReady_q  <= txReady_d;
      mosiByte_q <= mosiByte_d;
      mosiDv_q   <= mosiDv_d;
      rxDv_q     <= rxDv_d;
      rxByte_q   <= rxByte_d;
      rxCount_q  <= rxCount_d;
      rxIdx_q    <= rxIdx_d;
      remain_q   <= remain_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    csN_d      = csN_q;
    mosiByte_d = mosiByte_q;
    mosiDv_d   = 1'b0;
    rxDv_d     = 1'b0;
    rxByte_d   = rxByte_q;
    rxCount_d  = rxCount_q;
    rxIdx_d    = rxIdx_q;
    remain_d   = remain_q;
    timer_d    = timer_q;

    case (state_q)
      S_IDLE: begin
        if (accept && (i_TX_Count != '0)) begin
          mosiByte_d = i_TX_Byte;
          remain_d   = (i_TX_Count > MAX_CNT) ? MAX_CNT : i_TX_Count;
          rxIdx_d    = '0;
          timer_d    = '0;
          state_d    = S_LEAD;
        end
      end
      // CS drops on the first LEAD cycle, so lead time is counted from the fall.
      S_LEAD: begin
        csN_d = 1'b0;
        if (timer_q == LEAD_LAST) begin
          timer_d = '0;
          state_d = S_SEND;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SEND: begin
        if (i_M_MOSI_Ready) begin
          mosiDv_d = 1'b1;
          remain_d = remain_q - 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_M_MISO_DV) begin
          rxDv_d    = 1'b1;
          rxByte_d  = i_M_MISO_Byte;
          rxCount_d = rxIdx_q;
          rxIdx_d   = rxIdx_q + 1'b1;
          timer_d   = '0;
          state_d   = (remain_q != '0) ? S_NEXT : S_TRAIL;
        end
      end
      S_NEXT: begin
        if (accept) begin
          mosiByte_d = i_TX_Byte;
          state_d    = S_SEND;
        end
      end
      // Only cycles where the master reports ready count toward the trail.
      S_TRAIL: begin
        if (i_M_MOSI_Ready) begin
          if (timer_q == TRAIL_LAST) begin
            timer_d = '0;
            csN_d   = 1'b1;
            state_d = S_GAP;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (timer_q == IDLE_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is registered from the upcoming state so it is high exactly in IDLE/NEXT.
  assign txReady_d = (state_d == S_IDLE) || (state_d == S_NEXT);

  assign o_TX_Ready    = txReady_q;
  assign o_RX_Count    = rxCount_q;
  assign o_RX_DV       = rxDv_q;
  assign o_RX_Byte     = rxByte_q;
  assign o_M_MOSI_Byte = mosiByte_q;
  assign o_M_MOSI_DV   = mosiDv_q;
  assign o_SPI_CS_n    = csN_q;

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Scoreboard bench for spi_cs_sequencer with a behavioural loopback SPI_Master
// (CLKS_PER_HALF_BIT=2, so 32 clocks per byte).
module tb_spi_cs_sequencer;

  localparam int CNT_W    = 3;
  localparam int SPI_CLKS = 32;
  localparam int BOUND    = 3000;

  logic             clock = 1'b0;
  logic             rstN  = 1'b1;
  logic [CNT_W-1:0] txCount = '0;
  logic [7:0]       txByte  = '0;
  logic             txDv    = 1'b0;
  logic             txReady;
  logic [CNT_W-1:0] rxCount;
  logic             rxDv;
  logic [7:0]       rxByte;
  logic [7:0]       mosiByte;
  logic             mosiDv;
  logic             mReady;
  logic             mMisoDv;
  logic [7:0]       mMisoByte;
  logic             cs;

  spi_cs_sequencer dut (
    .i_Clk          (clock),
    .i_Rst_n        (rstN),
    .i_TX_Count     (txCount),
    .i_TX_Byte      (txByte),
    .i_TX_DV        (txDv),
    .o_TX_Ready     (txReady),
    .o_RX_Count     (rxCount),
    .o_RX_DV        (rxDv),
    .o_RX_Byte      (rxByte),
    .o_M_MOSI_Byte  (mosiByte),
    .o_M_MOSI_DV    (mosiDv),
    .i_M_MOSI_Ready (mReady),
    .i_M_MISO_DV    (mMisoDv),
    .i_M_MISO_Byte  (mMisoByte),
    .o_SPI_CS_n     (cs)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]       data;
    logic [CNT_W-1:0] idx;
  } rxExp_t;

  rxExp_t     expRx[$];
  logic [7:0] expMosi[$];
  int checkCount = 0;
  int passCount  = 0;
  int mosiDvSeen = 0;
  int rxDvSeen   = 0;
  int csRises    = 0;
  int csFalls    = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  // Loopback SPI_Master model: echoes each MOSI byte, ready returns 2 clocks after MISO_DV.
  logic [7:0] modelByte;
  initial begin
    mReady = 1'b1; mMisoDv = 1'b0; mMisoByte = '0; modelByte = '0;
    forever begin
      @(posedge clock); #1;
      if (mosiDv === 1'b1) begin
        modelByte = mosiByte;
        mReady = 1'b0;
        repeat (SPI_CLKS) @(posedge clock);
        #1;
        mMisoByte = modelByte;
        mMisoDv   = 1'b1;
        @(posedge clock); #1;
        mMisoDv = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        mReady = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a MOSI or RX pulse.
  logic   prevCs;
  rxExp_t popped;
  initial begin
    prevCs = 1'b1;
    forever begin
      @(negedge clock);
      if (mosiDv === 1'b1) begin
        mosiDvSeen++;
        checkOutput("csLowDuringMosi", cs, 0);
        if (expMosi.size() == 0) checkOutput("mosiUnexpected", 1, 0);
        else checkOutput("mosiByte", mosiByte, expMosi.pop_front());
      end
      if (rxDv === 1'b1) begin
        rxDvSeen++;
        if (expRx.size() == 0) checkOutput("rxUnexpected", 1, 0);
        else begin
          popped = expRx.pop_front();
          checkOutput("rxByte", rxByte, popped.data);
          checkOutput("rxIndex", rxCount, popped.idx);
        end
      end
      if (cs && !prevCs) csRises++;
      if (!cs && prevCs) csFalls++;
      prevCs = cs;
    end
  end

  task automatic waitReady();
    int n = 0;
    while (txReady !== 1'b1 && n < BOUND) begin @(negedge clock); n++; end
    if (n >= BOUND) checkOutput("txReadyTimeout", 0, 1);
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clock);
    while (!(txReady === 1'b1 && cs === 1'b1) && n < BOUND) begin @(negedge clock); n++; end
    if (n >= BOUND) checkOutput("idleTimeout", 0, 1);
  endtask

  task automatic waitRx();
    int n = 0;
    @(negedge clock);
    while (rxDv !== 1'b1 && n < BOUND) begin @(negedge clock); n++; end
    if (n >= BOUND) checkOutput("rxTimeout", 0, 1);
  endtask

  task automatic waitCsHigh();
    int n = 0;
    while (cs !== 1'b1 && n < BOUND) begin @(negedge clock); n++; end
    if (n >= BOUND) checkOutput("csHighTimeout", 0, 1);
  endtask

  // Offers one byte; returns at the falling edge just after the accepting edge.
  task automatic applyStimulus(input int count, input logic [7:0] data, input int idx);
    @(negedge clock);
    waitReady();
    txCount = CNT_W'(count);
    txByte  = data;
    txDv    = 1'b1;
    if (count != 0) begin
      expMosi.push_back(data);
      expRx.push_back('{data: data, idx: CNT_W'(idx)});
    end
    @(posedge clock);
    @(negedge clock);
    txDv = 1'b0;
  endtask

  initial begin
    #(2_000_000);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int snapMosi, snapRx, snapRise, snapFall, bad, n;
  initial begin
    #1 rstN = 1'b0;
    #1;
    checkOutput("rstCs", cs, 1);
    checkOutput("rstReady", txReady, 0);
    checkOutput("rstMosiDv", mosiDv, 0);
    checkOutput("rstRxDv", rxDv, 0);
    checkOutput("rstMosiByte", mosiByte, 0);
    checkOutput("rstRxByte", rxByte, 0);
    checkOutput("rstRxCount", rxCount, 0);
    repeat (3) @(negedge clock);
    checkOutput("rstReadyHeld", txReady, 0);
    rstN = 1'b1;
    @(negedge clock);
    checkOutput("readyAfterRelease", txReady, 1);

    $display("[TB] single byte 0x75");
    applyStimulus(1, 8'h75, 0);
    checkOutput("t1CsHighAtAccept", cs, 1);
    @(negedge clock);
    checkOutput("t1CsFall", cs, 0);
    checkOutput("t1DvEarly1", mosiDv, 0);
    @(negedge clock);
    checkOutput("t1DvEarly2", mosiDv, 0);
    @(negedge clock);
    checkOutput("t1MosiDv", mosiDv, 1);
    @(negedge clock);
    checkOutput("t1MosiDvOnePulse", mosiDv, 0);
    waitRx();
    // Master ready returns 3 clocks after RX; 2 ready clocks later CS rises, then 4 idle clocks.
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      checkOutput($sformatf("t1CsTrail%0d", i), cs, (i >= 4) ? 1 : 0);
      checkOutput($sformatf("t1ReadyGap%0d", i), txReady, (i >= 8) ? 1 : 0);
    end
    waitIdle();

    $display("[TB] three bytes back to back");
    snapMosi = mosiDvSeen; snapRx = rxDvSeen; snapRise = csRises; snapFall = csFalls;
    applyStimulus(3, 8'hA1, 0);
    applyStimulus(3, 8'hB2, 1);
    applyStimulus(3, 8'hC3, 2);
    waitIdle();
    checkOutput("t2MosiPulses", mosiDvSeen - snapMosi, 3);
    checkOutput("t2RxPulses", rxDvSeen - snapRx, 3);
    checkOutput("t2CsRises", csRises - snapRise, 1);
    checkOutput("t2CsFalls", csFalls - snapFall, 1);

    $display("[TB] user stall");
    snapRise = csRises;
    applyStimulus(2, 8'h39, 0);
    waitReady();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (cs !== 1'b0 || txReady !== 1'b1) bad++;
    end
    checkOutput("t3StallHold", bad, 0);
    applyStimulus(2, 8'h5A, 1);
    waitIdle();
    checkOutput("t3CsRises", csRises - snapRise, 1);

    $display("[TB] count zero");
    snapMosi = mosiDvSeen; snapFall = csFalls;
    applyStimulus(0, 8'h11, 0);
    repeat (20) @(negedge clock);
    checkOutput("t4ZeroMosi", mosiDvSeen - snapMosi, 0);
    checkOutput("t4ZeroCsFalls", csFalls - snapFall, 0);
    checkOutput("t4ZeroCs", cs, 1);
    checkOutput("t4ZeroReady", txReady, 1);

    $display("[TB] count 7 clamps to 4");
    snapMosi = mosiDvSeen; snapRise = csRises;
    applyStimulus(7, 8'hC0, 0);
    applyStimulus(7, 8'hC1, 1);
    applyStimulus(7, 8'hC2, 2);
    applyStimulus(7, 8'hC3, 3);
    waitIdle();
    checkOutput("t4ClampMosi", mosiDvSeen - snapMosi, 4);
    checkOutput("t4ClampCsRises", csRises - snapRise, 1);

    $display("[TB] ignored valid in TRAIL and GAP");
    snapMosi = mosiDvSeen; snapRx = rxDvSeen;
    applyStimulus(1, 8'h66, 0);
    waitRx();
    txByte = 8'hFF; txCount = CNT_W'(1); txDv = 1'b1;
    repeat (2) @(negedge clock);
    txDv = 1'b0;
    waitCsHigh();
    txDv = 1'b1;
    @(negedge clock);
    txDv = 1'b0;
    waitIdle();
    repeat (40) @(negedge clock);
    checkOutput("t5MosiPulses", mosiDvSeen - snapMosi, 1);
    checkOutput("t5RxPulses", rxDvSeen - snapRx, 1);

    $display("[TB] reset mid-transaction");
    snapMosi = mosiDvSeen;
    applyStimulus(3, 8'h10, 0);
    applyStimulus(3, 8'h20, 1);
    n = 0;
    while (mosiDvSeen < snapMosi + 2 && n < BOUND) begin @(negedge clock); n++; end
    if (n >= BOUND) checkOutput("t6SecondByteTimeout", 0, 1);
    repeat (5) @(negedge clock);
    rstN = 1'b0;
    #1;
    checkOutput("t6RstCs", cs, 1);
    checkOutput("t6RstReady", txReady, 0);
    checkOutput("t6RstMosiDv", mosiDv, 0);
    checkOutput("t6RstRxDv", rxDv, 0);
    checkOutput("t6RstMosiByte", mosiByte, 0);
    checkOutput("t6RstRxByte", rxByte, 0);
    checkOutput("t6RstRxCount", rxCount, 0);
    expRx.delete();
    repeat (3) @(negedge clock);
    rstN = 1'b1;
    @(negedge clock);
    checkOutput("t6ReadyAfterRelease", txReady, 1);
    applyStimulus(1, 8'h42, 0);
    waitIdle();
    repeat (10) @(negedge clock);
    checkOutput("rxQueueEmpty", expRx.size(), 0);
    checkOutput("mosiQueueEmpty", expMosi.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/spi_cs_sequencer.md
Name: spi_cs_sequencer

Overview:
Transaction-level front end that sits directly upstream of SPI_Master. It accepts an N-byte transfer on a valid/ready byte stream and feeds it byte by byte into SPI_Master's i_MOSI_Byte/i_MOSI_DV/o_MOSI_Ready interface. It owns the active-low chip select, including lead, trail and minimum-idle timing. It forwards each MISO byte from SPI_Master back to the user, tagged with its index in the transaction.

Parameters:
MAX_BYTES_PER_CS, 4, largest byte count per CS assertion.
CS_LEAD_CLKS, 2, i_Clk cycles from CS_n falling to the first byte issue; must be at least 1.
CS_TRAIL_CLKS, 2, i_Clk cycles from final byte completion to CS_n rising; must be at least 1.
CS_IDLE_CLKS, 4, minimum i_Clk cycles CS_n stays high before the next transaction; must be at least 1.
CNT_W, $clog2(MAX_BYTES_PER_CS+1), width of the count fields.

Ports:
i_Clk  in  1  system clock, all logic on rising edge.
i_Rst_n  in  1  asynchronous active-low reset.
i_TX_Count  in  CNT_W  byte count of the transaction; sampled only when the first byte is accepted.
i_TX_Byte  in  8  user byte to transmit.
i_TX_DV  in  1  user byte valid.
o_TX_Ready  out  1  sequencer can accept a byte this cycle.
o_RX_Count  out  CNT_W  0-based index of o_RX_Byte within the transaction.
o_RX_DV  out  1  one-cycle pulse; o_RX_Byte and o_RX_Count are valid.
o_RX_Byte  out  8  received byte.
o_M_MOSI_Byte  out  8  connects to SPI_Master i_MOSI_Byte.
o_M_MOSI_DV  out  1  connects to SPI_Master i_MOSI_DV.
i_M_MOSI_Ready  in  1  connects from SPI_Master o_MOSI_Ready.
i_M_MISO_DV  in  1  connects from SPI_Master o_MISO_DV.
i_M_MISO_Byte  in  8  connects from SPI_Master o_MISO_Byte.
o_SPI_CS_n  out  1  chip select to the slave, active low.

Behaviour:
- Reset (async, immediate):
  - State IDLE; o_SPI_CS_n=1.
  - o_TX_Ready, o_M_MOSI_DV and o_RX_DV are 0.
  - o_M_MOSI_Byte, o_RX_Byte and o_RX_Count are 0; all internal counters are 0.
  - o_TX_Ready is registered and rises on the first i_Clk edge after i_Rst_n deasserts.
- Byte acceptance: a byte is accepted on an edge where i_TX_DV=1 and o_TX_Ready=1. o_TX_Ready is high only in IDLE and in NEXT. i_TX_DV at any other time is ignored.
- IDLE, on accept:
  - i_TX_Count=0: byte dropped, stay in IDLE, CS_n unchanged.
  - i_TX_Count>MAX_BYTES_PER_CS: count clamped to MAX_BYTES_PER_CS.
  - Otherwise: latch the byte and the remaining count, clear the RX index, drive CS_n=0 on the next cycle, go to LEAD.
- LEAD: hold for CS_LEAD_CLKS cycles, then go to SEND.
- SEND:
  - When i_M_MOSI_Ready=1, drive o_M_MOSI_Byte with the latched byte and pulse o_M_MOSI_DV for exactly one cycle.
  - Decrement the remaining count and go to WAIT.
  - If i_M_MOSI_Ready=0, stay in SEND.
- WAIT:
  - On i_M_MISO_DV, register the byte: o_RX_DV pulses the next cycle with o_RX_Byte and the current index, then the index increments.
  - If remaining>0, go to NEXT; else go to TRAIL.
- NEXT: CS_n held low and o_TX_Ready=1 indefinitely; on accept, latch the byte and go to SEND. i_TX_Count is ignored here.
- TRAIL:
  - The counter advances only while i_M_MOSI_Ready=1, so CS never rises before SPI_Master finishes its last edge.
  - After CS_TRAIL_CLKS counted cycles, drive CS_n=1 and go to GAP.
- GAP: o_TX_Ready=0 for CS_IDLE_CLKS cycles, then go to IDLE.
- Latency: accept at edge k gives CS_n=0 after edge k+1. o_M_MOSI_DV is high in cycle k+1+CS_LEAD_CLKS if SPI_Master is ready.
- Reset mid-transaction: CS_n goes high asynchronously and any pending RX pulse is discarded. Resending the transaction is the user's responsibility.
- Simultaneous i_M_MISO_DV and a user byte in WAIT cannot occur, because o_TX_Ready=0 in WAIT.

Test Plan:
- Single byte, loopback MISO=MOSI, SPI_Master CLKS_PER_HALF_BIT=2: send count 1, byte 0x75 -> expect:
  - CS_n falls 1 cycle after accept, one o_M_MOSI_DV pulse 2 cycles later.
  - o_RX_DV with 0x75 at index 0.
  - CS_n rises 2 ready cycles after completion; o_TX_Ready returns 4 cycles after CS_n rises.
- Three bytes back to back: send count 3, bytes 0xA1, 0xB2, 0xC3 -> expect CS_n low continuously, exactly 3 DV pulses, RX bytes 0xA1/0xB2/0xC3 at indices 0/1/2.
- User stall: count 2, byte 0x39, then hold i_TX_DV=0 for 50 cycles before byte 0x5A -> expect CS_n low throughout the stall, o_TX_Ready=1 during the stall, RX 0x39 then 0x5A.
- Count edge cases:
  - count 0 with byte 0x11 -> no DV and CS_n stays 1.
  - count 7 -> only 4 bytes sent, CS_n rises after the 4th.
- Ignored valid: pulse i_TX_DV with byte 0xFF during TRAIL and GAP -> no extra DV and no extra RX.
- Reset mid-transaction: assert i_Rst_n=0 during byte 2 of a 3-byte transfer -> CS_n=1 and all outputs at reset values immediately; after release, a new count-1 transfer of byte 0x42 completes normally with RX 0x42 at index 0.
